// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results in a small in-order FIFO.
// It also owns the architectural HI/LO registers and serves mfhi/mflo.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake
//   in_opcode, in_c     ALU opcode and primary result
//   in_hi, in_lo        ALU HI/LO result (mult/multu/div/divu)
//   in_zon              ALU flags {zero, overflow, negative}
//   out_valid/out_ready downstream handshake
//   out_opcode/data/zon head entry of the result buffer
//   hi_q, lo_q          architectural HI/LO registers
//   clr_sticky          clear request for the sticky overflow flag
//   ovf_sticky          sticky overflow flag
//
// Build option: define STICKY_OVF_EN to add the sticky overflow flag.
// Without it ovf_sticky is tied low and clr_sticky is ignored.

module alu_result_stage #(
    parameter int unsigned DEPTH   = 2,
    parameter logic [5:0]  OP_MFHI = 6'b010101,
    parameter logic [5:0]  OP_MFLO = 6'b010110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [31:0] in_c,
    input  logic [31:0] in_hi,
    input  logic [31:0] in_lo,
    input  logic [2:0]  in_zon,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_opcode,
    output logic [31:0] out_data,
    output logic [2:0]  out_zon,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    input  logic        clr_sticky,
    output logic        ovf_sticky
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [5:0] OP_MULT  = 6'b000111;
    localparam logic [5:0] OP_MULTU = 6'b001000;
    localparam logic [5:0] OP_DIV   = 6'b001001;
    localparam logic [5:0] OP_DIVU  = 6'b001010;

    // Result buffer storage; the head entry drives the outputs directly.
    logic [5:0]    r_op_mem   [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];
    logic [2:0]    r_zon_mem  [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_wr_nxt;
    logic [AW-1:0] w_rd_nxt;

    logic          w_is_muldiv;
    logic          w_is_mfhi;
    logic          w_is_mflo;
    logic [31:0]   w_st_data;
    logic [2:0]    w_st_zon;

    // ------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // A pop in the same cycle frees the slot a full buffer needs.
    // Holding in_ready low during reset blocks any accept there.
    assign in_ready = rst_n && (!w_full || out_ready);

    assign w_push = in_valid && in_ready;
    assign w_pop  = !w_empty && out_ready;

    // Explicit wrap keeps the pointers correct for any DEPTH.
    assign w_wr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
    assign w_rd_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;

    // ------------------------------------------------------------
    // Opcode decode and stored-result selection
    // ------------------------------------------------------------
    assign w_is_muldiv = (in_opcode == OP_MULT)  ||
                         (in_opcode == OP_MULTU) ||
                         (in_opcode == OP_DIV)   ||
                         (in_opcode == OP_DIVU);
    assign w_is_mfhi   = (in_opcode == OP_MFHI);
    assign w_is_mflo   = (in_opcode == OP_MFLO);

    always_comb begin
        w_st_data = in_c;
        w_st_zon  = in_zon;
        unique case (1'b1)
            w_is_muldiv: begin
                w_st_data = in_lo;
            end
            // mfhi/mflo read the register value before this edge;
            // the ALU flags are meaningless here so they are rebuilt.
            w_is_mfhi: begin
                w_st_data = r_hi;
                w_st_zon  = {(r_hi == 32'd0), 1'b0, r_hi[31]};
            end
            w_is_mflo: begin
                w_st_data = r_lo;
                w_st_zon  = {(r_lo == 32'd0), 1'b0, r_lo[31]};
            end
            default: begin
                w_st_data = in_c;
                w_st_zon  = in_zon;
            end
        endcase
    end

    // ------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_op_mem[i]   <= '0;
                r_data_mem[i] <= '0;
                r_zon_mem[i]  <= '0;
            end
        end else if (w_push) begin
            r_op_mem[r_wr_ptr]   <= in_opcode;
            r_data_mem[r_wr_ptr] <= w_st_data;
            r_zon_mem[r_wr_ptr]  <= w_st_zon;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------
    // Architectural HI/LO: updated on accept, not on delivery
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_push && w_is_muldiv) begin
            r_hi <= in_hi;
            r_lo <= in_lo;
        end
    end

    // ------------------------------------------------------------
    // Sticky overflow
    // ------------------------------------------------------------
`ifdef STICKY_OVF_EN
    logic r_ovf_sticky;

    // A new overflow entry wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_push && w_st_zon[1]) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_sticky;
    assign ovf_sticky   = 1'b0;
`endif

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign out_valid  = !w_empty;
    assign out_opcode = r_op_mem[r_rd_ptr];
    assign out_data   = r_data_mem[r_rd_ptr];
    assign out_zon    = r_zon_mem[r_rd_ptr];
    assign hi_q       = r_hi;
    assign lo_q       = r_lo;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.

module tb_alu_result_stage;

    localparam int unsigned DEPTH = 2;
    localparam logic [5:0]  MFHI  = 6'b010101;
    localparam logic [5:0]  MFLO  = 6'b010110;
`ifdef STICKY_OVF_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [31:0] in_c;
    logic [31:0] in_hi;
    logic [31:0] in_lo;
    logic [2:0]  in_zon;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [31:0] out_data;
    logic [2:0]  out_zon;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        clr_sticky;
    logic        ovf_sticky;

    int n_checks = 0;
    int n_err    = 0;

    alu_result_stage #(
        .DEPTH   (DEPTH),
        .OP_MFHI (MFHI),
        .OP_MFLO (MFLO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_c       (in_c),
        .in_hi      (in_hi),
        .in_lo      (in_lo),
        .in_zon     (in_zon),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_data   (out_data),
        .out_zon    (out_zon),
        .hi_q       (hi_q),
        .lo_q       (lo_q),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] data;
        logic [2:0]  zon;
    } ent_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] c;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [2:0]  zon;
        logic [31:0] e_data;
        logic [2:0]  e_zon;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_stk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [5:0] op, logic [31:0] c,
                         logic [31:0] hi, logic [31:0] lo,
                         logic [2:0] zon);
        in_valid  = v;
        in_opcode = op;
        in_c      = c;
        in_hi     = hi;
        in_lo     = lo;
        in_zon    = zon;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;
        m_q.delete();
        m_hi  = '0;
        m_lo  = '0;
        m_stk = 1'b0;
    endtask

    function automatic bit is_muldiv(logic [5:0] op);
        return op == 6'b000111 || op == 6'b001000 ||
               op == 6'b001001 || op == 6'b001010;
    endfunction

    function automatic ent_t model_entry(logic [5:0] op,
                                         logic [31:0] c,
                                         logic [31:0] lo,
                                         logic [2:0] zon);
        ent_t e;
        e.op = op;
        if (is_muldiv(op)) begin
            e.data = lo;
            e.zon  = zon;
        end else if (op == MFHI || op == MFLO) begin
            e.data = (op == MFHI) ? m_hi : m_lo;
            e.zon  = {e.data == 32'd0, 1'b0, e.data[31]};
        end else begin
            e.data = c;
            e.zon  = zon;
        end
        return e;
    endfunction

    task automatic rand_cycle();
        logic [1:0] sel;
        logic [5:0] op;
        bit         exp_rdy;
        bit         acc;
        bit         pop;
        ent_t       e;
        sel = 2'($urandom_range(0, 3));
        if (sel == 2'd0)
            op = 6'($urandom_range(7, 10));
        else if (sel == 2'd1)
            op = ($urandom_range(0, 1) == 0) ? MFHI : MFLO;
        else
            op = 6'($urandom_range(0, 63));
        drive(1'($urandom_range(0, 1)), op,
              ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom(),
              ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom(),
              ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom(),
              3'($urandom_range(0, 7)));
        out_ready  = 1'($urandom_range(0, 1));
        clr_sticky = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        exp_rdy = (m_q.size() < DEPTH) || out_ready;
        chk("rand in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = in_valid && exp_rdy;
        pop = (m_q.size() > 0) && out_ready;
        e   = model_entry(in_opcode, in_c, in_lo, in_zon);
        tick();
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_q.push_back(e);
            if (is_muldiv(e.op)) begin
                m_hi = in_hi;
                m_lo = in_lo;
            end
        end
        if (STK) begin
            if (acc && e.zon[1]) m_stk = 1'b1;
            else if (clr_sticky) m_stk = 1'b0;
        end
        chk("rand out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("rand out_opcode", 32'(out_opcode), 32'(m_q[0].op));
            chk("rand out_data", out_data, m_q[0].data);
            chk("rand out_zon", 32'(out_zon), 32'(m_q[0].zon));
        end
        chk("rand hi_q", hi_q, m_hi);
        chk("rand lo_q", lo_q, m_lo);
        chk("rand ovf_sticky", 32'(ovf_sticky), 32'(m_stk));
    endtask

    vec_t vt[14];

    initial begin
        vt[0]  = '{6'b000001, 32'h9E1E1E1D, 32'h0, 32'h0, 3'b011,
                   32'h9E1E1E1D, 3'b011, 32'h0, 32'h0};
        vt[1]  = '{6'b000010, 32'h0, 32'hAAAA, 32'hBBBB, 3'b100,
                   32'h0, 3'b100, 32'h0, 32'h0};
        vt[2]  = '{MFHI, 32'hDEADBEEF, 32'h1, 32'h1, 3'b011,
                   32'h0, 3'b100, 32'h0, 32'h0};
        vt[3]  = '{6'b000111, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   3'b001, 32'hFFFFFFFF, 3'b001,
                   32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[4]  = '{MFHI, 32'h0, 32'h0, 32'h0, 3'b100,
                   32'hFFFFFFFF, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[5]  = '{6'b001010, 32'h9, 32'h5, 32'h3, 3'b000,
                   32'h3, 3'b000, 32'h5, 32'h3};
        vt[6]  = '{MFHI, 32'h0, 32'h0, 32'h0, 3'b111,
                   32'h5, 3'b000, 32'h5, 32'h3};
        vt[7]  = '{MFLO, 32'h0, 32'h0, 32'h0, 3'b111,
                   32'h3, 3'b000, 32'h5, 32'h3};
        vt[8]  = '{6'b001000, 32'h1, 32'h80000000, 32'h0, 3'b100,
                   32'h0, 3'b100, 32'h80000000, 32'h0};
        vt[9]  = '{MFHI, 32'h0, 32'h0, 32'h0, 3'b000,
                   32'h80000000, 3'b001, 32'h80000000, 32'h0};
        vt[10] = '{6'b111111, 32'h7FFFFFFF, 32'h1, 32'h1, 3'b010,
                   32'h7FFFFFFF, 3'b010, 32'h80000000, 32'h0};
        vt[11] = '{6'b001001, 32'h0, 32'h0, 32'hFFFFFFFE, 3'b001,
                   32'hFFFFFFFE, 3'b001, 32'h0, 32'hFFFFFFFE};
        vt[12] = '{MFLO, 32'h0, 32'h0, 32'h0, 3'b100,
                   32'hFFFFFFFE, 3'b001, 32'h0, 32'hFFFFFFFE};
        vt[13] = '{6'b010100, 32'h1, 32'h0, 32'h0, 3'b000,
                   32'h1, 3'b000, 32'h0, 32'hFFFFFFFE};

        // Reset state
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        #3;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_opcode", 32'(out_opcode), 32'd0);
        chk("rst out_zon", 32'(out_zon), 32'd0);
        chk("rst hi_q", hi_q, 32'd0);
        chk("rst lo_q", lo_q, 32'd0);
        chk("rst ovf_sticky", 32'(ovf_sticky), 32'd0);
        do_reset();

        // Vector table, one entry at a time with out_ready high
        for (int i = 0; i < 14; i++) begin
            out_ready = 1'b1;
            drive(1'b1, vt[i].op, vt[i].c, vt[i].hi, vt[i].lo,
                  vt[i].zon);
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d out_opcode", i), 32'(out_opcode),
                32'(vt[i].op));
            chk($sformatf("vec%0d out_data", i), out_data, vt[i].e_data);
            chk($sformatf("vec%0d out_zon", i), 32'(out_zon),
                32'(vt[i].e_zon));
            chk($sformatf("vec%0d hi_q", i), hi_q, vt[i].e_hi);
            chk($sformatf("vec%0d lo_q", i), lo_q, vt[i].e_lo);
            tick();
            chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
        end

        // Full buffer: back-pressure, then pop+push in one cycle
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 6'b000001, 32'hA, 32'h0, 32'h0, 3'b000);
        tick();
        drive(1'b1, 6'b000001, 32'hB, 32'h0, 32'h0, 3'b000);
        tick();
        drive(1'b1, 6'b000001, 32'hC, 32'h0, 32'h0, 3'b000);
        #1;
        chk("full in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("full head", out_data, 32'hA);
        out_ready = 1'b1;
        #1;
        chk("full+pop in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("order 2nd", out_data, 32'hB);
        chk("order valid", 32'(out_valid), 32'd1);
        tick();
        chk("order 3rd", out_data, 32'hC);
        tick();
        chk("order empty", 32'(out_valid), 32'd0);

        // Reset mid-operation with two entries buffered
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 6'b000111, 32'h0, 32'h12345678, 32'h9ABCDEF0,
              3'b000);
        tick();
        drive(1'b1, 6'b000001, 32'h5, 32'h0, 32'h0, 3'b000);
        tick();
        in_valid = 1'b0;
        chk("pre-rst valid", 32'(out_valid), 32'd1);
        chk("pre-rst hi_q", hi_q, 32'h12345678);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 32'(out_valid), 32'd0);
        chk("mid-rst hi_q", hi_q, 32'd0);
        chk("mid-rst lo_q", lo_q, 32'd0);
        chk("mid-rst in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post-rst valid", 32'(out_valid), 32'd0);
        tick();
        chk("post-rst valid2", 32'(out_valid), 32'd0);

        // Sticky overflow set, hold, clear, set-wins-over-clear
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 6'b000001, 32'h1, 32'h0, 32'h0, 3'b010);
        tick();
        in_valid = 1'b0;
        chk("stk set", 32'(ovf_sticky), 32'(STK));
        tick();
        tick();
        chk("stk hold", 32'(ovf_sticky), 32'(STK));
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("stk clr", 32'(ovf_sticky), 32'd0);
        drive(1'b1, 6'b000001, 32'h2, 32'h0, 32'h0, 3'b010);
        clr_sticky = 1'b1;
        tick();
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        chk("stk set wins", 32'(ovf_sticky), 32'(STK));

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DEPTH, default 2, result buffer entries (power of two, 2..8).
REQ-002 Parameter OP_MFHI, default 6'b010101, opcode selecting HI as result.
REQ-003 Parameter OP_MFLO, default 6'b010110, opcode selecting LO as result.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  ALU result present.
REQ-007 in_ready  output  1  stage can accept a result.
REQ-008 in_opcode  input  6  ALU opcode (add=000001 .. slti=010100, plus OP_MFHI/OP_MFLO).
REQ-009 in_c  input  32  ALU primary result.
REQ-010 in_hi, in_lo  input  32 each  ALU HI/LO (mult/multu/div/divu).
REQ-011 in_zon  input  3  ALU flags: [2]=zero, [1]=overflow, [0]=negative.
REQ-012 out_valid  output  1  buffered result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_opcode  output  6  opcode of head entry.
REQ-015 out_data  output  32  result of head entry.
REQ-016 out_zon  output  3  flags of head entry.
REQ-017 hi_q, lo_q  output  32 each  architectural HI/LO registers.
REQ-018 clr_sticky  input  1  clears sticky overflow flag.
REQ-019 ovf_sticky  output  1  sticky overflow flag.

Function
REQ-020 Accept on in_valid&&in_ready; deliver on out_valid&&out_ready; one of each max per cycle.
REQ-021 Buffer SHALL be FIFO of DEPTH entries {opcode,data,zon}, in-order, registered outputs from head entry.
REQ-022 in_ready SHALL be 1 when not full, or when full and out_ready=1 (simultaneous pop frees slot same cycle).
REQ-023 out_valid SHALL be 1 iff FIFO non-empty; latency input-accept to out_valid = 1 cycle.
REQ-024 Empty with simultaneous push: pushed entry visible next cycle; no combinational in-to-out bypass.
REQ-025 Full with simultaneous push and pop: both occur, occupancy unchanged.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-027 On accepted mult/multu (000111/001000) or div/divu (001001/001010): hi_q<=in_hi, lo_q<=in_lo, stored data=in_lo.
REQ-028 On accepted OP_MFHI/OP_MFLO: stored data=hi_q/lo_q value before that edge, stored zon={data==0,1'b0,data[31]}.
REQ-029 All other opcodes: stored data=in_c, stored zon=in_zon, HI/LO unchanged.
REQ-030 HI/LO SHALL update only on accept, independent of out_ready; rejected inputs change nothing.
REQ-031 Undefined opcodes SHALL be treated as REQ-029.

Reset
REQ-032 rst_n=0 SHALL immediately clear FIFO (out_valid=0), pointers, counter, hi_q, lo_q, ovf_sticky, out_opcode, out_data, out_zon to 0.
REQ-033 During reset in_ready=0; first accept possible on first edge after rst_n rises.
REQ-034 Reset mid-operation SHALL discard all buffered entries; no partial delivery after release.

Configuration
REQ-035 Macro STICKY_OVF_EN: defined -> ovf_sticky sets on any accepted entry with stored zon[1]=1, clears on clr_sticky=1; set wins when both same cycle.
REQ-036 STICKY_OVF_EN undefined -> ovf_sticky tied 0, clr_sticky ignored, no sticky register.

Verification
REQ-037 add a=40404040 b=5DDDDDDD, out_ready=1 -> next cycle out_data=9E1E1E1D, out_zon=011.
REQ-038 mult a=FFFFFFFF b=00000001 then OP_MFHI -> hi_q=FFFFFFFF, lo_q=FFFFFFFF; mfhi entry out_data=FFFFFFFF, zon=001.
REQ-039 out_ready=0, push 3 entries (DEPTH=2) -> in_ready=0 after 2nd; raise out_ready with in_valid -> pop+push same cycle, order preserved.
REQ-040 sub a=b=5DDDDDDD -> out_data=0, out_zon=100; HI/LO unchanged.
REQ-041 Two entries buffered, assert rst_n=0 mid-cycle -> out_valid=0 immediately; hi_q=lo_q=0.
REQ-042 STICKY_OVF_EN defined: add with zon=010 -> ovf_sticky=1 held; clr_sticky pulse -> 0; clr with overflow entry same cycle -> stays 1.
